// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the divider-sharing arbiter.
// The divider latency constant sets the nominal gnt-to-rsp_valid distance of 20 cycles.
package div_pkg;
   localparam int DIV_N_REQ = 4;
   localparam int DIV_W     = 8;
   localparam int DIV_TMO   = 24;
   localparam int DIV_LAT   = 18;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GRANT  = 3'd1,
      S_LAUNCH = 3'd2,
      S_WAIT   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/division_block.sv
// Iterative signed divider: restoring division on magnitudes, fixed latency of LAT cycles.
// Operands are read live every step, so the caller must hold them for the whole operation.
module division_block
   import div_pkg::*;
#(
   parameter  int W   = DIV_W,
   parameter  int LAT = DIV_LAT,
   localparam int CW  = $clog2(LAT + 1),
   localparam int BW  = (W > 1) ? $clog2(W) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_q,
   output logic         o_done_division
);
   logic [W-1:0]  w_mag_a, w_mag_b;
   logic [W:0]    w_rem_sh;
   logic          w_ge;
   logic          r_run, r_post_rst;
   logic [CW-1:0] r_cnt;
   logic [BW-1:0] r_bit;
   logic [W-1:0]  r_rem, r_quo;

   assign w_mag_a  = i_a[W-1] ? -i_a : i_a;
   assign w_mag_b  = i_b[W-1] ? -i_b : i_b;
   assign w_rem_sh = {r_rem, w_mag_a[r_bit]};
   assign w_ge     = (w_rem_sh >= {1'b0, w_mag_b});

   assign o_q             = (i_a[W-1] ^ i_b[W-1]) ? -r_quo : r_quo;
   // The cycle after reset release carries a stray done pulse that consumers must ignore.
   assign o_done_division = (r_run && (r_cnt == CW'(LAT - 1))) || r_post_rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run      <= 1'b0;
         r_post_rst <= 1'b1;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
      end else begin
         r_post_rst <= 1'b0;
         if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_bit <= BW'(W - 1);
            r_rem <= '0;
            r_quo <= '0;
         end else if (r_run) begin
            if (r_cnt < CW'(W)) begin
               r_rem <= w_ge ? (w_rem_sh[W-1:0] - w_mag_b) : w_rem_sh[W-1:0];
               r_quo <= {r_quo[W-2:0], w_ge};
               r_bit <= r_bit - BW'(1);
            end
            if (r_cnt == CW'(LAT - 1)) r_run <= 1'b0;
            else                       r_cnt <= r_cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above i_ptr, with wrap.
module rr_arbiter
   import div_pkg::*;
#(
   parameter  int N_REQ = DIV_N_REQ,
   localparam int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IW-1:0]    o_idx,
   output logic             o_any
);
   always_comb begin
      int j;
      j     = 0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(i_ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!o_any && i_req[j]) begin
            o_any    = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/div_arbiter.sv
// Shares one signed divider among N_REQ requesters: round-robin grant, launch, wait
// with watchdog, then a one-cycle response carrying the owner's index and quotient.
module div_arbiter
   import div_pkg::*;
#(
   parameter  int N_REQ = DIV_N_REQ,
   parameter  int W     = DIV_W,
   parameter  int TMO   = DIV_TMO,
   localparam int IW    = idx_w(N_REQ),
   localparam int TW    = $clog2(TMO + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ*W-1:0]   a_in,
   input  logic [N_REQ*W-1:0]   b_in,
   output logic [N_REQ-1:0]     gnt,
   output logic                 busy,
   output logic                 rsp_valid,
   output logic [IW-1:0]        rsp_id,
   output logic [W-1:0]         rsp_q,
   output logic                 rsp_zero,
   output logic                 rsp_err
);
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   state_t           r_state, w_next;
   logic [IW-1:0]    r_ptr, r_id, w_idx;
   logic [N_REQ-1:0] w_arb_gnt;
   logic             w_any, w_start, w_done, w_zero, w_tmo, w_div_rst;
   logic [W-1:0]     r_a, r_b, w_div_q, r_rsp_q;
   logic [TW-1:0]    r_wdog;
   logic [IW-1:0]    r_rsp_id;
   logic             r_rsp_zero, r_rsp_err;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_div_rst = ~rst;

   division_block #(.W(W)) u_div (
      .clk             (clk),
      .rst             (w_div_rst),
      .i_start         (w_start),
      .i_a             (r_a),
      .i_b             (r_b),
      .o_q             (w_div_q),
      .o_done_division (w_done)
   );

   assign w_zero = (r_a == '0) || (r_b == '0) || (r_a == MIN_VAL) || (r_b == MIN_VAL);
   assign w_tmo  = (r_wdog == TW'(TMO - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (|req) w_next = S_GRANT;
         S_GRANT:  w_next = w_any ? S_LAUNCH : S_IDLE;
         S_LAUNCH: w_next = S_WAIT;
         S_WAIT:   if (w_done || w_tmo) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      gnt       = '0;
      w_start   = 1'b0;
      rsp_valid = 1'b0;
      busy      = (r_state != S_IDLE);
      case (r_state)
         S_GRANT:  gnt       = w_arb_gnt;
         S_LAUNCH: w_start   = 1'b1;
         S_RESP:   rsp_valid = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr      <= '0;
         r_id       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_wdog     <= '0;
         r_rsp_id   <= '0;
         r_rsp_q    <= '0;
         r_rsp_zero <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else begin
         if (r_state == S_GRANT && w_any) begin
            r_id  <= w_idx;
            r_a   <= a_in[w_idx*W +: W];
            r_b   <= b_in[w_idx*W +: W];
            r_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
         end
         if (r_state == S_LAUNCH) r_wdog <= '0;
         if (r_state == S_WAIT)   r_wdog <= r_wdog + TW'(1);
         // A done in the same cycle as the watchdog limit still counts as success.
         if (r_state == S_WAIT && (w_done || w_tmo)) begin
            r_rsp_id   <= r_id;
            r_rsp_zero <= w_zero;
            r_rsp_err  <= !w_done;
            r_rsp_q    <= (w_zero || !w_done) ? '0 : w_div_q;
         end
      end
   end

   assign rsp_id   = r_rsp_id;
   assign rsp_q    = r_rsp_q;
   assign rsp_zero = r_rsp_zero;
   assign rsp_err  = r_rsp_err;
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one divider.
REQ-002 SHALL have parameter W, default 8, operand/quotient width in bits.
REQ-003 SHALL have parameter TMO, default 24, watchdog limit in cycles from start pulse to divider done.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  N_REQ  per-requester request, level, held until granted.
REQ-007 SHALL have port a_in  input  N_REQ*W  per-requester signed dividend, slice i = bits [i*W +: W].
REQ-008 SHALL have port b_in  input  N_REQ*W  per-requester signed divisor, same slicing.
REQ-009 SHALL have port gnt  output  N_REQ  one-hot, one-cycle accept pulse; operands sampled that cycle.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle result pulse.
REQ-012 SHALL have port rsp_id  output  clog2(N_REQ)  index of requester owning rsp_q.
REQ-013 SHALL have port rsp_q  output  W  signed quotient.
REQ-014 SHALL have port rsp_zero  output  1  operand a or b equal to 0 or -2^(W-1); rsp_q forced 0.
REQ-015 SHALL have port rsp_err  output  1  watchdog expiry; rsp_q forced 0.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, LAUNCH, WAIT, RESP.
REQ-017 IDLE: when any req is high, SHALL go to GRANT; otherwise stay.
REQ-018 GRANT: SHALL pulse gnt for the round-robin winner, latch its index and operands into a_reg/b_reg, then go to LAUNCH.
REQ-019 Round-robin: SHALL search from pointer ptr upward with wrap; after a grant ptr SHALL become (winner+1) mod N_REQ.
REQ-020 A req dropped before its grant SHALL NOT be granted; a req changing between IDLE and GRANT SHALL use the GRANT-cycle value; if none is high in GRANT, SHALL return to IDLE with no gnt.
REQ-021 LAUNCH: SHALL drive divider start high for exactly one cycle, clear the watchdog counter, then go to WAIT.
REQ-022 a_reg/b_reg SHALL remain stable from LAUNCH through RESP; the divider reads operands combinationally mid-operation.
REQ-023 WAIT: on divider done_division high, SHALL capture divider q that cycle and go to RESP.
REQ-024 WAIT: when watchdog reaches TMO without done, SHALL set the error flag and go to RESP.
REQ-025 done_division outside WAIT (including the pulse the divider emits after its own reset) SHALL be ignored.
REQ-026 RESP: SHALL pulse rsp_valid one cycle with rsp_id, rsp_q, rsp_zero, rsp_err, then go to IDLE.
REQ-027 rsp_zero SHALL be computed from a_reg/b_reg; when set, rsp_q = 0 regardless of divider output.
REQ-028 rsp_q, rsp_id, rsp_zero and rsp_err SHALL hold their values until the next RESP.
REQ-029 Nominal latency: gnt at cycle g, start at g+1, rsp_valid at g+20; at most one operation in flight.
REQ-030 gnt and rsp_valid SHALL never be high in the same cycle.

Reset
REQ-031 On rst low: state IDLE, ptr 0, gnt 0, busy 0, rsp_valid 0, rsp_id 0, rsp_q 0, rsp_zero 0, rsp_err 0, watchdog 0.
REQ-032 The divider's synchronous active-high rst SHALL be driven from the inverted rst.
REQ-033 Reset asserted mid-operation SHALL abort it silently with no rsp_valid, and the first grant after release SHALL go to requester 0.

Structure
REQ-034 State encodings, W, N_REQ defaults and TMO SHALL live in shared package div_pkg.
REQ-035 Round-robin selection SHALL be sub-module rr_arbiter (req, ptr in; one-hot grant and index out, combinational); division_block SHALL be instantiated once inside div_arbiter.

Verification
REQ-036 req0, a=100, b=7 -> gnt[0] one cycle, rsp_valid 20 cycles later, rsp_id=0, rsp_q=14, rsp_zero=0.
REQ-037 req2, a=-100 (8'h9C), b=7 -> rsp_id=2, rsp_q=-14 (8'hF2).
REQ-038 req1, a=50, b=0 -> rsp_q=0, rsp_zero=1; then a=-128, b=3 -> rsp_q=0, rsp_zero=1.
REQ-039 req=4'b1111 held, operands differ per requester -> grant order 0,1,2,3,0; each rsp_id matches its grant.
REQ-040 rst low for 2 cycles during WAIT -> no rsp_valid; post-reset spurious done ignored; next req3 completes normally with rsp_id=3.
REQ-041 Divider done forced low (bench override) -> rsp_valid after TMO with rsp_err=1 and rsp_q=0.
